// File: rtl/s_count_monitor_pkg.sv
// Shared types and defaults for the s_count_monitor slice.
//   DEF_*        default parameter values for the monitor
//   mon_state_e  FSM state encoding (IDLE=0, ACQ=1, LOCK=2)
//   mon_evt_t    per-sample event pair raised while LOCKED
package s_count_monitor_pkg;

  localparam int unsigned DEF_WIDTH  = 4;
  localparam int unsigned DEF_LOCK_N = 2;
  localparam int unsigned DEF_WRAP_W = 8;
  localparam int unsigned DEF_ERR_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } mon_state_e;

  typedef struct packed {
    logic wrap;
    logic err;
  } mon_evt_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset  clock and synchronous active-high reset
//   clr         clears q to 0; together with inc, q becomes 1
//   inc         increments q, holding at all-ones
//   q           counter value
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // A coincident increment wins over clear, so the new event is counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr && inc) begin
      q <= W'(1);
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/s_count_monitor.sv
// Monitor for a free-running +1 count bus: acquires lock after LOCK_N
// clean steps, then reports wraps and step errors.
//   clk, reset   clock and synchronous active-high reset
//   count_valid  qualifies count; when 0 nothing advances and pulses drop
//   count        monitored count value
//   err_clr      clears err_flag and err_cnt (a coincident error wins)
//   locked       FSM is in LOCKED
//   wrap_pulse   one-cycle pulse on an all-ones -> 0 step while LOCKED
//   wrap_cnt     wraps seen while LOCKED, rolls over
//   err_pulse    one-cycle pulse on a step error while LOCKED
//   err_flag     sticky error indicator
//   err_cnt      errors seen while LOCKED, saturating
module s_count_monitor
  import s_count_monitor_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned LOCK_N = DEF_LOCK_N,
  parameter int unsigned WRAP_W = DEF_WRAP_W,
  parameter int unsigned ERR_W  = DEF_ERR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              count_valid,
  input  logic [WIDTH-1:0]  count,
  input  logic              err_clr,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err_pulse,
  output logic              err_flag,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int unsigned RUN_W = $clog2(LOCK_N + 1);

  mon_state_e       state_q, state_d;
  logic [WIDTH-1:0] prev_q;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic             step_ok;
  mon_evt_t         evt;

  assign step_ok = (count == WIDTH'(prev_q + WIDTH'(1)));
  assign run_inc = run_q + RUN_W'(1);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, clean-step run length and LOCKED events.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    evt     = '0;
    if (count_valid) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQ;
          run_d   = '0;
        end
        ST_ACQ: begin
          if (!step_ok) begin
            run_d = '0;
          end else if (run_inc == RUN_W'(LOCK_N)) begin
            state_d = ST_LOCK;
            run_d   = '0;
          end else begin
            run_d = run_inc;
          end
        end
        ST_LOCK: begin
          if (step_ok) begin
            // step_ok already implies count==0 when prev is all-ones.
            evt.wrap = (prev_q == '1);
          end else begin
            evt.err = 1'b1;
            state_d = ST_ACQ;
            run_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          run_d   = '0;
        end
      endcase
    end
  end

  // Sample history, run counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q     <= '0;
      run_q      <= '0;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= '0;
      err_pulse  <= 1'b0;
      err_flag   <= 1'b0;
    end else begin
      if (count_valid) begin
        prev_q <= count;
      end
      run_q      <= run_d;
      locked     <= (state_d == ST_LOCK);
      wrap_pulse <= evt.wrap;
      err_pulse  <= evt.err;
      if (evt.wrap) begin
        wrap_cnt <= wrap_cnt + WRAP_W'(1);
      end
      if (evt.err) begin
        err_flag <= 1'b1;
      end else if (err_clr) begin
        err_flag <= 1'b0;
      end
    end
  end

  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (err_clr),
    .inc   (evt.err),
    .q     (err_cnt)
  );

endmodule
